// File: rtl/bitwise_stream_reducer.sv
// rtl/bitwise_stream_reducer.sv - valid/ready bitwise AND/OR/XOR/ANDN engine with element-wise and frame-reduction modes
// One registered output stage; frames fold all beats up to in_last with the op latched at frame start.
module bitwise_stream_reducer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_reduce,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero,
    output logic             out_ones
);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_ANDN = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       op_q;
    logic [1:0]       op_next;

    logic             fire;
    logic             load;
    logic [1:0]       eff_op;
    logic [WIDTH-1:0] f_ab;
    logic [WIDTH-1:0] folded;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt_out_next;

    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_ANDN: r = a & ~b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // ANDN has no associative self-combine; its masked terms are gathered with OR.
    function automatic logic [WIDTH-1:0] combine(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = x & y;
            OP_XOR:  r = x ^ y;
            default: r = x | y;
        endcase
        return r;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign fire     = in_valid && in_ready;
    assign eff_op   = (state == ACCUM) ? op_q : in_op;
    assign f_ab     = apply_op(eff_op, in_a, in_b);
    assign folded   = combine(op_q, acc, f_ab);
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    always_comb begin
        state_next   = state;
        acc_next     = acc;
        cnt_next     = cnt;
        op_next      = op_q;
        load         = 1'b0;
        res_next     = '0;
        cnt_out_next = '0;
        if (fire) begin
            case (state)
                IDLE: begin
                    if (in_reduce && !in_last) begin
                        acc_next   = f_ab;
                        cnt_next   = CNT_ONE;
                        op_next    = in_op;
                        state_next = ACCUM;
                    end else begin
                        load         = 1'b1;
                        res_next     = f_ab;
                        cnt_out_next = CNT_ONE;
                    end
                end
                ACCUM: begin
                    if (in_last) begin
                        load         = 1'b1;
                        res_next     = folded;
                        cnt_out_next = cnt_inc;
                        acc_next     = '0;
                        cnt_next     = '0;
                        state_next   = IDLE;
                    end else begin
                        acc_next = folded;
                        cnt_next = cnt_inc;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            op_q  <= OP_AND;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            op_q  <= op_next;
        end
    end

    // A load while the current result is being popped keeps out_valid high for full throughput.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_count  <= '0;
            out_zero   <= 1'b1;
            out_ones   <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_result <= res_next;
            out_count  <= cnt_out_next;
            out_zero   <= (res_next == '0);
            out_ones   <= &res_next;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bitwise_stream_reducer.sv
// tb/tb_bitwise_stream_reducer.sv - table, directed and randomized scoreboard bench for bitwise_stream_reducer
module tb_bitwise_stream_reducer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_op;
    logic        in_reduce;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [7:0]  out_count;
    logic        out_zero;
    logic        out_ones;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_result2;
    logic [1:0]  out_count2;
    logic        out_zero2;
    logic        out_ones2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bitwise_stream_reducer #(.WIDTH(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_reduce(in_reduce), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_count(out_count), .out_zero(out_zero), .out_ones(out_ones)
    );

    bitwise_stream_reducer #(.WIDTH(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_reduce(in_reduce), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
        .out_count(out_count2), .out_zero(out_zero2), .out_ones(out_ones2)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic        red;
        logic        last;
        logic [31:0] res;
        logic [7:0]  cnt;
        logic        zero;
        logic        ones;
    } vec_t;

    vec_t vecs[6];

    // Reference model state: beats of the open frame kept as a list, folded on close.
    logic        m_open;
    logic [1:0]  m_op;
    logic [31:0] m_vals[$];
    logic [31:0] exp_res[$];
    int          exp_cnt[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0: return a & b;
            2'd1: return a | b;
            2'd2: return a ^ b;
            default: return a & ~b;
        endcase
    endfunction

    function automatic logic [31:0] ref_r(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            2'd0: return x & y;
            2'd2: return x ^ y;
            default: return x | y;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 4)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic red, input logic last);
        int t;
        in_a = a; in_b = b; in_op = op; in_reduce = red; in_last = last; in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic model_accept();
        logic [31:0] r;
        int n;
        if (!m_open) begin
            if (in_reduce && !in_last) begin
                m_open = 1'b1;
                m_op   = in_op;
                m_vals.delete();
                m_vals.push_back(ref_f(in_op, in_a, in_b));
            end else begin
                exp_res.push_back(ref_f(in_op, in_a, in_b));
                exp_cnt.push_back(1);
            end
        end else begin
            m_vals.push_back(ref_f(m_op, in_a, in_b));
            if (in_last) begin
                r = m_vals[0];
                for (int i = 1; i < m_vals.size(); i++) r = ref_r(m_op, r, m_vals[i]);
                n = (m_vals.size() > 255) ? 255 : m_vals.size();
                exp_res.push_back(r);
                exp_cnt.push_back(n);
                m_open = 1'b0;
            end
        end
    endtask

    task automatic cycle_check();
        logic [31:0] er;
        int ec;
        @(negedge clk);
        check("rand_in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
        if (out_valid && out_ready) begin
            if (exp_res.size() == 0) begin
                check("rand_unexpected_out", 32'd1, 32'd0);
            end else begin
                er = exp_res.pop_front();
                ec = exp_cnt.pop_front();
                check("rand_result", out_result, er);
                check("rand_count", {24'd0, out_count}, ec);
                check("rand_zero", {31'd0, out_zero}, {31'd0, (er == 32'd0)});
                check("rand_ones", {31'd0, out_ones}, {31'd0, (er == 32'hFFFF_FFFF)});
            end
        end
        if (in_valid && in_ready) model_accept();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'hF0F0_0000, 32'h0000_0F0F, 2'd1, 1'b0, 1'b0, 32'hF0F0_0F0F, 8'd1, 1'b0, 1'b0};
        vecs[1] = '{32'h1234_5678, 32'h0F0F_0F0F, 2'd0, 1'b0, 1'b0, 32'h0204_0608, 8'd1, 1'b0, 1'b0};
        vecs[2] = '{32'hAAAA_AAAA, 32'h5555_5555, 2'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 8'd1, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_0000, 32'hFFFF_FFFF, 2'd3, 1'b0, 1'b0, 32'h0000_0000, 8'd1, 1'b1, 1'b0};
        vecs[4] = '{32'h0F0F_0F0F, 32'h00FF_00FF, 2'd2, 1'b1, 1'b1, 32'h0FF0_0FF0, 8'd1, 1'b0, 1'b0};
        vecs[5] = '{32'hC3C3_C3C3, 32'h0F0F_0F0F, 2'd3, 1'b0, 1'b0, 32'hC0C0_C0C0, 8'd1, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        in_reduce = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_count", {24'd0, out_count}, 32'd0);
        check("rst_out_zero", {31'd0, out_zero}, 32'd1);
        check("rst_out_ones", {31'd0, out_ones}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].red, vecs[i].last);
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_result", i), out_result, vecs[i].res);
            check($sformatf("vec%0d_count", i), {24'd0, out_count}, {24'd0, vecs[i].cnt});
            check($sformatf("vec%0d_zero", i), {31'd0, out_zero}, {31'd0, vecs[i].zero});
            check($sformatf("vec%0d_ones", i), {31'd0, out_ones}, {31'd0, vecs[i].ones});
        end
        @(posedge clk); #1;
        check("pop_clears_valid", {31'd0, out_valid}, 32'd0);

        // OR frame of three beats
        send(32'h1, 32'h0, 2'd1, 1'b1, 1'b0);
        check("or_frame_mid1_valid", {31'd0, out_valid}, 32'd0);
        send(32'h2, 32'h0, 2'd1, 1'b1, 1'b0);
        check("or_frame_mid2_valid", {31'd0, out_valid}, 32'd0);
        send(32'h4, 32'h0, 2'd1, 1'b1, 1'b1);
        check("or_frame_valid", {31'd0, out_valid}, 32'd1);
        check("or_frame_result", out_result, 32'h0000_0007);
        check("or_frame_count", {24'd0, out_count}, 32'd3);

        // XOR frame; op and reduce changes on beat 2 must be ignored
        send(32'hFFFF_FFFF, 32'h0, 2'd2, 1'b1, 1'b0);
        send(32'h0000_FFFF, 32'h0, 2'd0, 1'b0, 1'b1);
        check("xor_frame_result", out_result, 32'hFFFF_0000);
        check("xor_frame_count", {24'd0, out_count}, 32'd2);

        // Backpressure and back-to-back handover
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 1'b0, 1'b0);
        check("bp_ones", {31'd0, out_ones}, 32'd1);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        in_a = 32'h1; in_b = 32'h2; in_op = 2'd1; in_reduce = 1'b0; in_last = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_hold%0d_result", k), out_result, 32'hFFFF_FFFF);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_b2b_valid", {31'd0, out_valid}, 32'd1);
        check("bp_b2b_result", out_result, 32'h0000_0003);
        check("bp_b2b_count", {24'd0, out_count}, 32'd1);
        @(posedge clk); #1;
        check("bp_no_dup_valid", {31'd0, out_valid}, 32'd0);

        // Counter saturation on the CNT_W=2 instance
        for (int k = 0; k < 5; k++) send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 1'b1, (k == 4));
        check("sat_count", {30'd0, out_count2}, 32'd3);
        check("sat_result", out_result2, 32'hFFFF_FFFF);
        check("sat_ones", {31'd0, out_ones2}, 32'd1);
        check("nosat_count", {24'd0, out_count}, 32'd5);

        // Reset in the middle of an open frame
        @(posedge clk); #1;
        send(32'h1, 32'h1, 2'd1, 1'b1, 1'b0);
        send(32'h2, 32'h2, 2'd1, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        send(32'h0000_00FF, 32'h0000_000F, 2'd3, 1'b0, 1'b0);
        check("midrst_elem_valid", {31'd0, out_valid}, 32'd1);
        check("midrst_elem_result", out_result, 32'h0000_00F0);
        check("midrst_elem_count", {24'd0, out_count}, 32'd1);
        send(32'h10, 32'h0, 2'd1, 1'b1, 1'b0);
        send(32'h20, 32'h0, 2'd1, 1'b1, 1'b1);
        check("midrst_frame_result", out_result, 32'h0000_0030);
        check("midrst_frame_count", {24'd0, out_count}, 32'd2);

        // Randomized traffic against the list-folding model
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_open = 1'b0;
        m_op = 2'd0;
        m_vals.delete();
        exp_res.delete();
        exp_cnt.delete();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 4) != 0;
            in_a      = pick();
            in_b      = pick();
            in_op     = 2'($urandom);
            in_reduce = ($urandom % 3) != 0;
            in_last   = ($urandom % 4) == 0;
            out_ready = ($urandom % 4) != 0;
            cycle_check();
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            cycle_check();
        end
        check("rand_drained", exp_res.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
